sobel_stream_filter: RTL and testbench
======================================

SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 8: pixels per row, minimum 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default 8: rows per frame, minimum 3.
REQ-003 SHALL have parameter PIX_W, default 8: pixel bit width for input and output, range 4-16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: arms a frame when sampled high in IDLE.
REQ-007 SHALL have port pixel_in, input, PIX_W bits: raster-order input pixel.
REQ-008 SHALL have port pixel_valid, input, 1 bit: pixel_in is accepted on each cycle this is high in RUN; gaps are allowed.
REQ-009 SHALL have port threshold, input, PIX_W bits: edge threshold, used only under SOBEL_THRESHOLD_EN.
REQ-010 SHALL have port pixel_out, output, PIX_W bits: edge magnitude.
REQ-011 SHALL have port pixel_out_valid, output, 1 bit: pixel_out is valid this cycle.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
- IDLE->RUN: start=1.
- RUN->FLUSH: the cycle after the IMG_WIDTH*IMG_HEIGHT-th pixel is accepted.
- FLUSH->DONE: pipeline empty.
- DONE->IDLE: unconditionally after one cycle.
REQ-014 SHALL ignore pixel_valid outside RUN, and ignore start outside IDLE.
REQ-015 SHALL track column and row of the accepted pixel with counters.
- The column counter wraps from IMG_WIDTH-1 to 0 and increments the row counter.
- Both counters clear on entry to RUN.
REQ-016 SHALL hold the previous two rows in two line buffers of IMG_WIDTH x PIX_W and form a 3x3 window.
- The window advances only on accepted pixels.
- A stall (pixel_valid=0) freezes all window and pipeline state.
REQ-017 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20) and Gy=(p20+2p21+p22)-(p00+2p01+p02) in signed PIX_W+4 bits, where p<row><col> and row 0 is the oldest row.
REQ-018 SHALL compute magnitude |Gx|+|Gy| in PIX_W+4 bits, saturated to 2^PIX_W-1.
REQ-019 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame, in row-major order.
- The output for the window with top-left (r,c) is produced when pixel (r+2,c+2) is accepted.
- No outputs are produced for border positions or row-wrap windows.
REQ-020 SHALL assert pixel_out_valid exactly 2 clk cycles after acceptance of pixel (r+2,c+2), independent of later stalls: a fixed 2-stage pipeline.
REQ-021 SHALL pulse done for one cycle, in state DONE, the cycle after the last pixel_out_valid.
REQ-022 SHALL hold pixel_out at its last value when pixel_out_valid=0.

Reset
REQ-023 SHALL, while rst_n=0 at a clk edge:
- set the state to IDLE;
- clear the counters;
- set pixel_out=0, pixel_out_valid=0 and done=0;
- clear pipeline valid flags.
Line buffer contents need not be cleared.
REQ-024 SHALL, on reset mid-frame, abandon the frame with no further outputs; the next frame requires a new start.

Configuration
REQ-025 SHALL, when macro SOBEL_THRESHOLD_EN is defined, output 2^PIX_W-1 if saturated magnitude >= threshold, else 0, with latency unchanged.
REQ-026 SHALL, without SOBEL_THRESHOLD_EN, output the saturated magnitude and leave threshold unused.

Verification
REQ-027 SHALL cover a flat frame: 8x8, all pixels 100 -> 36 outputs all 0; done pulses once, one cycle after the 36th output.
REQ-028 SHALL cover a vertical step: columns 0-3=0, columns 4-7=200 -> output columns 2 and 3 equal 255 (800 saturated) in every row; all other outputs 0.
REQ-029 SHALL cover stalls: the step frame with pixel_valid toggling 1/0 each cycle -> an identical 36-value sequence, each output 2 cycles after its completing pixel.
REQ-030 SHALL cover threshold mode: SOBEL_THRESHOLD_EN defined, threshold=128, 8x8 ramp with pixel(r,c)=10c -> Gx=80, all 36 outputs 0; with threshold=80, all 36 outputs 255.
REQ-031 SHALL cover reset mid-frame: rst_n low for 1 cycle after 20 pixels -> no pixel_out_valid and no done; a fresh start and full frame then yield exactly 36 outputs.
REQ-032 SHALL cover a spurious start: start held high throughout RUN -> a single frame of 36 outputs, with no restart.

Source files
------------

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: raster pixels in, saturated |Gx|+|Gy| out after a fixed 2-cycle pipeline.
// Optional macro SOBEL_THRESHOLD_EN turns the magnitude into a binary edge map against `threshold`.
module sobel_stream_filter #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] threshold,
  output logic [PIX_W-1:0] pixel_out,
  output logic             pixel_out_valid,
  output logic             done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PIX_W + 4;
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = {PIX_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;
  logic              accept_s, last_pix_s;
  logic              win_valid_r, grad_valid_r;
  logic [PIX_W-1:0]  lb0_r [IMG_WIDTH];
  logic [PIX_W-1:0]  lb1_r [IMG_WIDTH];
  logic [PIX_W-1:0]  win_r [3][3];
  logic signed [GW-1:0] gx_s, gy_s, gx_r, gy_r;
  logic [PIX_W-1:0]  result_s;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({4'b0000, p});
  endfunction

  function automatic logic [PIX_W-1:0] sat_mag(input logic signed [GW-1:0] gx,
                                               input logic signed [GW-1:0] gy);
    logic [GW-1:0] ax, ay, sum;
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    sum = ax + ay;
    if (sum > {4'b0000, PIX_MAX}) begin
      return PIX_MAX;
    end else begin
      return sum[PIX_W-1:0];
    end
  endfunction

  assign accept_s   = (state_r == RUN) && pixel_valid;
  assign last_pix_s = accept_s && (col_r == COL_LAST) && (row_r == ROW_LAST);

  // Next-state logic; FLUSH waits until only the output stage may still hold data.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:  if (start) state_next_s = RUN; else state_next_s = IDLE;
      RUN:   if (last_pix_s) state_next_s = FLUSH; else state_next_s = RUN;
      FLUSH: if (!win_valid_r && !grad_valid_r) state_next_s = DONE; else state_next_s = FLUSH;
      DONE:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Gradients of the registered window; row 0 is the oldest image row.
  always_comb begin
    gx_s = (ext(win_r[0][2]) + (ext(win_r[1][2]) <<< 1) + ext(win_r[2][2]))
         - (ext(win_r[0][0]) + (ext(win_r[1][0]) <<< 1) + ext(win_r[2][0]));
    gy_s = (ext(win_r[2][0]) + (ext(win_r[2][1]) <<< 1) + ext(win_r[2][2]))
         - (ext(win_r[0][0]) + (ext(win_r[0][1]) <<< 1) + ext(win_r[0][2]));
  end

`ifdef SOBEL_THRESHOLD_EN
  // Binary edge decision on the saturated magnitude.
  always_comb begin
    result_s = {PIX_W{1'b0}};
    if (sat_mag(gx_r, gy_r) >= threshold) begin
      result_s = PIX_MAX;
    end else begin
      result_s = {PIX_W{1'b0}};
    end
  end
`else
  logic unused_threshold_s;
  assign unused_threshold_s = ^threshold;

  // Plain saturated magnitude.
  always_comb begin
    result_s = sat_mag(gx_r, gy_r);
  end
`endif

  // Control state, counters, pipeline valid flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      col_r           <= {CW{1'b0}};
      row_r           <= {RW{1'b0}};
      win_valid_r     <= 1'b0;
      grad_valid_r    <= 1'b0;
      pixel_out       <= {PIX_W{1'b0}};
      pixel_out_valid <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == IDLE) && start) begin
        col_r <= {CW{1'b0}};
        row_r <= {RW{1'b0}};
      end else if (accept_s) begin
        if (col_r == COL_LAST) begin
          col_r <= {CW{1'b0}};
          row_r <= row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      // Only interior windows (full 3x3 inside one row band) produce output.
      win_valid_r     <= accept_s && (row_r >= RW'(2)) && (col_r >= CW'(2));
      grad_valid_r    <= win_valid_r;
      pixel_out_valid <= grad_valid_r;
      if (grad_valid_r) begin
        pixel_out <= result_s;
      end
      done <= (state_next_s == DONE);
    end
  end

  // Line buffers and window advance only on accepted pixels; gradient stage is free-running.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_r[col_r] <= lb1_r[col_r];
      lb1_r[col_r] <= pixel_in;
      for (int i = 0; i < 3; i++) begin
        win_r[i][0] <= win_r[i][1];
        win_r[i][1] <= win_r[i][2];
      end
      win_r[0][2] <= lb0_r[col_r];
      win_r[1][2] <= lb1_r[col_r];
      win_r[2][2] <= pixel_in;
    end
    if (win_valid_r) begin
      gx_r <= gx_s;
      gy_r <= gy_s;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter: driver pushes reference outputs, negedge monitor pops and compares.
module tb_sobel_stream_filter;
  localparam int W = 8, H = 8, PW = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0, rst_n, start, pixel_valid, pixel_out_valid, done;
  logic [PW-1:0] pixel_in, threshold, pixel_out;

  sobel_stream_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .threshold(threshold), .pixel_out(pixel_out),
    .pixel_out_valid(pixel_out_valid), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int tests = 0, fails = 0;
  int exp_q[$], due_q[$];
  int out_cnt = 0, done_cnt = 0, last_out_cyc = -10, last_val = 0;
  int img [H][W];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: direct 3x3 Sobel on the stored frame, window top-left (r,c).
  function automatic int model(input int r, input int c, input int thr);
    int gx, gy, mag;
    gx = (img[r][c+2] + 2*img[r+1][c+2] + img[r+2][c+2]) - (img[r][c] + 2*img[r+1][c] + img[r+2][c]);
    gy = (img[r+2][c] + 2*img[r+2][c+1] + img[r+2][c+2]) - (img[r][c] + 2*img[r][c+1] + img[r][c+2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > (1 << PW) - 1) mag = (1 << PW) - 1;
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= thr) ? (1 << PW) - 1 : 0;
`else
    return mag;
`endif
  endfunction

  // Monitor: every valid output must match the head of the scoreboard at the promised cycle.
  always @(negedge clk) begin
    if (pixel_out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("pixel_out", pixel_out, exp_q.pop_front());
        check("out_latency", cyc, due_q.pop_front());
      end
      out_cnt++;
      last_out_cyc = cyc;
      last_val = pixel_out;
    end else if (rst_n) begin
      check("pixel_out_hold", pixel_out, last_val);
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_out", cyc, last_out_cyc + 1);
      check("done_queue_empty", exp_q.size(), 0);
    end
  end

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0: img[r][c] = 100;
          1: img[r][c] = (c < 4) ? 0 : 200;
          2: img[r][c] = 10 * c;
          default: img[r][c] = $urandom_range(0, 255);
        endcase
  endtask

  task automatic send_pixel(input int r, input int c, input bit gap, input int thr);
    if (gap) begin
      pixel_valid = 1'b0;
      pixel_in = PW'($urandom);
      @(posedge clk); #1;
    end
    pixel_valid = 1'b1;
    pixel_in = PW'(img[r][c]);
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    if (r >= 2 && c >= 2) begin
      exp_q.push_back(model(r - 2, c - 2, thr));
      due_q.push_back(cyc + 2);
    end
  endtask

  // gapmode: 0 none, 1 alternate valid/idle, 2 random gaps
  task automatic run_frame(input int gapmode, input bit hold_start, input int thr);
    bit gap;
    threshold = PW'(thr);
    out_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        gap = (gapmode == 1) ? 1'b1 : (gapmode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        send_pixel(r, c, gap, thr);
      end
    start = 1'b0;
    for (int i = 0; i < 100 && done_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("outputs_per_frame", out_cnt, NOUT);
    check("done_pulses", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; pixel_valid = 1'b0; pixel_in = '0; threshold = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pixel_out", pixel_out, 0);
    check("reset_valid", pixel_out_valid, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fill(0); run_frame(0, 1'b0, 0);    // flat
    fill(1); run_frame(0, 1'b0, 0);    // vertical step
    fill(1); run_frame(1, 1'b0, 0);    // step with alternating stalls
    fill(2); run_frame(0, 1'b0, 128);  // ramp, high threshold
    fill(2); run_frame(2, 1'b0, 80);   // ramp, threshold at gradient

    // Reset after 20 pixels: frame abandoned, nothing more comes out.
    fill(3);
    out_cnt = 0; done_cnt = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 20; i++) send_pixel(i / W, i % W, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); due_q.delete(); last_val = 0;
    check("midreset_pixel_out", pixel_out, 0);
    for (int i = 0; i < 12; i++) begin
      pixel_valid = 1'b1; pixel_in = PW'($urandom);
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset_no_outputs", out_cnt, 0);
    check("midreset_no_done", done_cnt, 0);
    fill(3); run_frame(0, 1'b0, 0);

    // start held high through RUN: single frame, and later pixels are ignored in IDLE.
    fill(3); run_frame(0, 1'b1, 0);
    out_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      pixel_valid = 1'b1; pixel_in = PW'($urandom);
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_ignores_pixels", out_cnt, 0);
    check("idle_no_done", done_cnt, 0);

    for (int k = 0; k < 3; k++) begin
      fill(3); run_frame(2, 1'b0, $urandom_range(0, 255));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
